// File: rtl/jtopl_wrbuf_pkg.sv
// jtopl_wrbuf_pkg
// Shared definitions for the OPL register-port write buffer:
//   - pacing FSM state enum
//   - default timing constants (reusable by an OPL3 variant)
//   - FIFO entry layout and a counter-width helper
package jtopl_wrbuf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } wrbuf_state_t;

    // Default pacing, in cen ticks
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_STROBE_LEN = 2;
    localparam int DEF_ADDR_WAIT  = 12;
    localparam int DEF_DATA_WAIT  = 84;

    localparam int ENTRY_W = 9;

    typedef struct packed {
        logic       addr;
        logic [7:0] data;
    } wr_entry_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Enough bits to hold (largest duration - 1); never narrower than 1 bit.
    function automatic int cnt_width(input int s, input int a, input int d);
        int m;
        m = max3(s, a, d);
        if (m <= 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/jtopl_wrfifo.sv
// jtopl_wrfifo
// Synchronous DEPTH x W FIFO with show-ahead read.
//   clk, rst : clock, synchronous active-high reset (flushes contents)
//   push     : write request; ignored while full (even if pop is high)
//   pop      : read request; ignored while empty
//   din      : write data
//   dout     : head entry (valid while level != 0)
//   full     : registered, level == DEPTH
//   level    : registered entry count
module jtopl_wrfifo #(
    parameter  int DEPTH = 16,
    parameter  int W     = 9,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_n;
    logic          push_ok;
    logic          pop_ok;

    // Admission uses the registered full flag, so a same-cycle pop never
    // makes room for a push.
    assign push_ok = push && !full;
    assign pop_ok  = pop && (level != '0);

    always_comb begin
        level_n = level;
        case ({push_ok, pop_ok})
            2'b10:   level_n = level + 1'b1;
            2'b01:   level_n = level - 1'b1;
            default: level_n = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_n;
            full  <= (level_n == LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/jtopl_wrbuf.sv
// jtopl_wrbuf
// Write buffer and pacer between the CPU bus and the jtopl register port.
// CPU writes are queued at bus speed and replayed as cs_n/wr_n strobes,
// each followed by the OPL recovery gap (longer after a data-port write).
//   rst, clk   : synchronous active-high reset, system clock
//   cen        : clock enable shared with jtopl; all pacing counts cen ticks
//   cpu_din    : write data
//   cpu_addr   : 0 = address port, 1 = data port
//   cpu_wr     : one-clk write request, sampled every clk
//   full       : FIFO full, a cpu_wr now is dropped
//   empty      : FIFO empty and pacer idle
//   level      : entries stored
//   overflow   : sticky drop flag, cleared only by rst
//   opl_din, opl_addr, opl_cs_n, opl_wr_n : to jtopl register port
//
// Handshake: cpu_wr acts as valid and !full as ready; a write is taken on
// any clk where cpu_wr && !full, otherwise it is lost and overflow is set.
module jtopl_wrbuf
    import jtopl_wrbuf_pkg::*;
#(
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int STROBE_LEN = DEF_STROBE_LEN,
    parameter  int ADDR_WAIT  = DEF_ADDR_WAIT,
    parameter  int DATA_WAIT  = DEF_DATA_WAIT,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_addr,
    input  logic          cpu_wr,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic [7:0]    opl_din,
    output logic          opl_addr,
    output logic          opl_cs_n,
    output logic          opl_wr_n
);

    localparam int CNT_W = cnt_width(STROBE_LEN, ADDR_WAIT, DATA_WAIT);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_LEN - 1);
    localparam logic [CNT_W-1:0] ADDR_LOAD   = CNT_W'(ADDR_WAIT - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD   = CNT_W'(DATA_WAIT - 1);

    wrbuf_state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             strobe_n, strobe_n_n;
    logic [7:0]       din_n;
    logic             addr_n;
    logic             fifo_pop;
    logic [8:0]       fifo_dout;
    wr_entry_t        head;

    assign head = wr_entry_t'(fifo_dout);

    jtopl_wrfifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu_wr),
        .pop   (fifo_pop),
        .din   ({cpu_addr, cpu_din}),
        .dout  (fifo_dout),
        .full  (full),
        .level (level)
    );

    // Pacing FSM: everything advances only on cen-high clocks, so strobe
    // and gap lengths are in cen ticks and each strobe spans STROBE_LEN
    // jtopl sample edges.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        strobe_n_n = strobe_n;
        din_n      = opl_din;
        addr_n     = opl_addr;
        fifo_pop   = 1'b0;
        if (cen) begin
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        fifo_pop   = 1'b1;
                        din_n      = head.data;
                        addr_n     = head.addr;
                        strobe_n_n = 1'b0;
                        cnt_n      = STROBE_LOAD;
                        state_n    = STROBE;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        strobe_n_n = 1'b1;
                        // Data-port writes need the long recovery gap.
                        cnt_n      = opl_addr ? DATA_LOAD : ADDR_LOAD;
                        state_n    = GAP;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    strobe_n_n = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            strobe_n <= 1'b1;
            opl_din  <= 8'h00;
            opl_addr <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            strobe_n <= strobe_n_n;
            opl_din  <= din_n;
            opl_addr <= addr_n;
            if (cpu_wr && full) overflow <= 1'b1;
        end
    end

    assign opl_cs_n = strobe_n;
    assign opl_wr_n = strobe_n;
    assign empty    = (level == '0) && (state == IDLE);

endmodule

// File: doc/jtopl_wrbuf.md
# jtopl_wrbuf

Write buffer and pacer between the CPU bus and the jtopl core's register port. CPU writes (address-port and data-port) are queued at bus speed in a small FIFO and replayed to the core as cs_n/wr_n strobes. Each replayed write is followed by the recovery gap a real OPL2 requires before the next write, so software never has to poll or insert delay loops. The core's status read path (dout, irq_n) bypasses this block.

## Interface
- DEPTH, 16, FIFO entries; power of two, 4..64
- STROBE_LEN, 2, cen ticks that cs_n/wr_n stay low per replayed write; ≥1
- ADDR_WAIT, 12, cen ticks of idle after an address-port write (addr=0)
- DATA_WAIT, 84, cen ticks of idle after a data-port write (addr=1)
- rst  in  1  reset; synchronous, active-high
- clk  in  1  system clock; one clock domain, shared with jtopl
- cen  in  1  clock enable; same signal that feeds jtopl.cen
- cpu_din  in  8  write data
- cpu_addr  in  1  0 = address port, 1 = data port
- cpu_wr  in  1  one-clk write request; sampled every clk, independent of cen
- full  out  1  FIFO full; a cpu_wr in this cycle is dropped
- empty  out  1  FIFO empty and no write in flight
- level  out  $clog2(DEPTH)+1  entries stored
- overflow  out  1  sticky; set when a cpu_wr is dropped, cleared only by rst
- opl_din  out  8  to jtopl.din
- opl_addr  out  1  to jtopl.addr
- opl_cs_n  out  1  to jtopl.cs_n
- opl_wr_n  out  1  to jtopl.wr_n

## Operation
- FIFO entry is {addr, data}, 9 bits.
- Push: cpu_wr && !full.
- cpu_wr && full: entry dropped and overflow set.
  - full is the registered flag. A pop in the same cycle does not admit the push.
- Push and pop in the same cycle (not full): level unchanged; both take effect.
- FSM states IDLE, STROBE, GAP. The FSM advances only on cen-high edges.
  - IDLE: if level≠0, pop the head. Load opl_din/opl_addr, drive opl_cs_n=opl_wr_n=0, load cnt=STROBE_LEN-1, go to STROBE.
  - STROBE: if cnt=0, drive cs_n=wr_n=1 and load cnt = (opl_addr ? DATA_WAIT : ADDR_WAIT)-1, go to GAP. Otherwise decrement cnt.
  - GAP: if cnt=0, go to IDLE. Otherwise decrement cnt.
- opl_din/opl_addr hold their last value outside STROBE; they never change while a strobe is low.
- empty = (level==0) && state==IDLE.
- Counter width is $clog2(max(STROBE_LEN, ADDR_WAIT, DATA_WAIT)) bits.
- rst in any state:
  - Flushes the FIFO and returns to IDLE.
  - Deasserts the strobes at that same edge. An aborted strobe is not retried.

## Timing
- Reset values: opl_cs_n=1, opl_wr_n=1, opl_din=0, opl_addr=0, full=0, empty=1, level=0, overflow=0, state IDLE.
- level/full/empty are registered; they update the clk after the push or pop.
- With cen=1 and FSM idle, cpu_wr at edge k:
  - entry stored at edge k;
  - strobe low from edge k+1 through edge k+1+STROBE_LEN (STROBE_LEN clk low);
  - next strobe no earlier than STROBE_LEN + wait + 1 cen ticks after the previous strobe start.
- With a divided cen, all strobe and gap durations are counted in cen ticks, never raw clk.
- Strobe low time always covers ≥1 cen-high edge, so jtopl samples each write exactly once.

## Structure
- Shared package jtopl_wrbuf_pkg holds:
  - the state enum (IDLE, STROBE, GAP);
  - the default timing constants, reused by any future OPL3 variant.
- One sub-module: jtopl_wrfifo, a synchronous FIFO (DEPTH×9) with push/pop/full/level.
  - The pacing FSM stays in jtopl_wrbuf.

## Test plan
- Address then data, cen=1: write (0,0x20) then (1,0x01) on consecutive clk.
  - Strobe 1 is 2 clk low with addr=0, din=0x20.
  - Strobe 2 starts exactly 2+12+1=15 clk after strobe 1 starts, with addr=1, din=0x01.
  - After strobe 2: empty rises 2+84 clk later.
- cen every 4th clk: same two writes; all durations scale ×4 and each strobe spans exactly 2 cen-high edges.
- Fill: 17 back-to-back cpu_wr with DEPTH=16 while idle. Since strobe 1 pops in the clk after write 1, writes 1-17 are all accepted; full=1 and level=16 after write 17.
  - An 18th cpu_wr while full=1 is dropped and sets overflow.
  - 17 strobes replay in order; overflow stays 1 until rst.
- Simultaneous push/pop: push while the FSM pops at level=3; level stays 3 and the data order is preserved.
- Reset mid-strobe: assert rst during STROBE with 5 entries queued.
  - Next edge: cs_n=wr_n=1, level=0, empty=1.
  - No further strobes until a new cpu_wr.
- Chain with jtopl: program timer A via the buffer (0x02←0xFF, 0x04←0x01) at full CPU rate. jtopl flag_A sets 4 sample periods later, as with a hand-paced write sequence.
